// File: rtl/seq_det_pkg.sv
// Shared types and the "001" Mealy step function for the time-shared detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

    typedef struct packed {
        state_t state;
        logic   det;
    } step_t;

    // Any unrecognised context encoding recovers to S0 without reporting a hit.
    function automatic step_t step_fn(input state_t s, input logic b);
        step_t r;
        r.state = S0;
        r.det   = 1'b0;
        case (s)
            S0:      r.state = b ? S0 : S1;
            S1:      r.state = b ? S0 : S2;
            S2: begin
                r.state = b ? S0 : S2;
                r.det   = b;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_det_step.sv
// Combinational "001" detector step shared by all channels.
module seq_det_step
    import seq_det_pkg::*;
(
    input  state_t state_in,
    input  logic   data_bit,
    output state_t state_out,
    output logic   det
);

    step_t res;

    always_comb begin
        res       = step_fn(state_in, data_bit);
        state_out = res.state;
        det       = res.det;
    end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one "001" detector step across N_CH serial channels.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_valid,
    input  logic [N_CH-1:0]  ch_bit,
    input  logic [N_CH-1:0]  ch_clear,
    output logic [N_CH-1:0]  ch_ready,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_det,
    output logic [CNT_W-1:0] hit_cnt
);

    state_t          ctx [N_CH];
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] ptr_next;
    logic            grant_any;
    state_t          step_state;
    logic            step_det;
    logic            det_eff;

    // First valid channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = CH_W'((32'(rr_ptr) + k) % N_CH);
            if (!grant_any && ch_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        ch_ready = '0;
        if (grant_any) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    seq_det_step u_step (
        .state_in  (ctx[grant_idx]),
        .data_bit  (ch_bit[grant_idx]),
        .state_out (step_state),
        .det       (step_det)
    );

    assign det_eff  = grant_any & step_det & ~ch_clear[grant_idx];
    assign ptr_next = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                ctx[i] <= S0;
            end
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_det   <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            out_valid <= grant_any;
            if (grant_any) begin
                rr_ptr         <= ptr_next;
                ctx[grant_idx] <= step_state;
                out_ch         <= grant_idx;
                out_det        <= det_eff;
                if (det_eff && hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end
            // Issued after the datapath write so a clear always wins.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (ch_clear[i]) begin
                    ctx[i] <= S0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched against a trailing-zero-count reference model.
module tb_seq_det_sched;

    localparam int N     = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  ch_valid = '0;
    logic [N-1:0]  ch_bit = '0;
    logic [N-1:0]  ch_clear = '0;
    logic [N-1:0]  ch_ready;
    logic          out_valid;
    logic [1:0]    out_ch;
    logic          out_det;
    logic [CW-1:0] hit_cnt;

    seq_det_sched #(.N_CH(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_valid  (ch_valid),
        .ch_bit    (ch_bit),
        .ch_clear  (ch_clear),
        .ch_ready  (ch_ready),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_det   (out_det),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int det;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  m_ptr = 0;
    int  m_cnt = 0;
    int  zeros[N];
    bit  mon_en = 1'b0;
    bit  rst_chk = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "001" completes when a 1 arrives after at least two 0s since the last 1/clear.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic r);
        int   g;
        int   det;
        ev_t  e;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        if (rst_chk) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_ch", int'(out_ch), 0);
            check("rst_out_det", int'(out_det), 0);
            check("rst_hit_cnt", int'(hit_cnt), 0);
            rst_chk = 1'b0;
            mon_en  = 1'b1;
        end
        ch_valid = v;
        ch_bit   = b;
        ch_clear = c;
        reset    = r;
        #1;
        g = model_grant(v);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (mon_en) check("ch_ready", int'(ch_ready), int'(exp_rdy));
        if (r) begin
            m_ptr = 0;
            m_cnt = 0;
            for (int i = 0; i < N; i++) zeros[i] = 0;
            rst_chk = 1'b1;
        end else begin
            if (g >= 0) begin
                det = (b[g] && zeros[g] >= 2 && !c[g]) ? 1 : 0;
                e.ch  = g;
                e.det = det;
                exp_q.push_back(e);
                if (det == 1 && m_cnt < CMAX) m_cnt++;
                zeros[g] = b[g] ? 0 : zeros[g] + 1;
                m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (c[i]) zeros[i] = 0;
            end
        end
    endtask

    task automatic send(input int ch, input logic bv, input logic cl);
        logic [N-1:0] v;
        logic [N-1:0] b;
        logic [N-1:0] c;
        v = '0; b = '0; c = '0;
        v[ch] = 1'b1;
        b[ch] = bv;
        c[ch] = cl;
        drive(v, b, c, 1'b0);
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 1'b1);
    endtask

    // Monitor: every registered event must match the next scoreboard entry.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_ch", int'(out_ch), e.ch);
                        check("out_det", int'(out_det), e.det);
                    end
                end else begin
                    check("out_valid", (out_valid === 1'b0) ? exp_q.size() : 99, 0);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                check("hit_cnt", int'(hit_cnt), m_cnt);
            end
        end
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic [7:0]   ch3_stream;
        for (int i = 0; i < N; i++) zeros[i] = 0;

        do_reset();
        do_reset();

        // Single channel 0,0,1
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0);
        drive('0, '0, '0, 1'b0);

        // All channels valid: strict rotation, each channel sees 0,0,1
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            b = (cyc / N == 2) ? '1 : '0;
            drive('1, b, '0, 1'b0);
        end
        drive('0, '0, '0, 1'b0);

        // Interleaved contexts on ch1 and ch2
        send(1, 1'b0, 1'b0);
        send(2, 1'b1, 1'b0);
        send(1, 1'b0, 1'b0);
        send(2, 1'b0, 1'b0);
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);

        // Clear colliding with a completing bit
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b1);
        send(0, 1'b1, 1'b0);

        // Stay in s2 and overlap on ch3
        ch3_stream = 8'b1001_0000;
        for (int i = 0; i < 8; i++) send(3, ch3_stream[i], 1'b0);

        // Saturate, then reset during a grant
        do_reset();
        for (int i = 0; i < 27; i++) send(0, (i % 3) == 2, 1'b0);
        drive('1, '1, '0, 1'b1);
        drive('0, '0, '0, 1'b0);

        // Randomized traffic with occasional clears and resets
        for (int cyc = 0; cyc < 600; cyc++) begin
            v = N'($urandom_range(0, 15));
            b = N'($urandom_range(0, 15));
            c = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
            drive(v, b, c, $urandom_range(0, 99) == 0);
        end
        drive('0, '0, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
